// File: rtl/param_data_stack.sv
// Parametrised LIFO data stack with single-cycle DUP/SWAP/OVER/REPLACE/BINOP,
// sticky overflow/underflow flags and registered top/second/count outputs.
module param_data_stack #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [2:0]             OP,
    input  logic                   OP_VALID,
    input  logic [WIDTH-1:0]       DATA_IN,
    input  logic                   CLEAR_ERR,
    output logic [WIDTH-1:0]       TOP_ITEM,
    output logic [WIDTH-1:0]       SECOND_ITEM,
    output logic [COUNT_WIDTH-1:0] ITEM_COUNT,
    output logic                   EMPTY,
    output logic                   FULL,
    output logic                   OVERFLOW,
    output logic                   UNDERFLOW,
    output logic                   OP_ERR
);

    localparam int IDX_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_DUP     = 3'd3,
        OP_SWAP    = 3'd4,
        OP_OVER    = 3'd5,
        OP_REPLACE = 3'd6,
        OP_BINOP   = 3'd7
    } op_e;

    op_e op;
    assign op = op_e'(OP);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [IDX_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic [WIDTH-1:0] second_q, second_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             err_q, err_d;

    logic [1:0]       needs;
    logic             room;
    logic             lack_items, lack_room, accept;
    logic [PTR_W-1:0] p_free, p_top, p_sec, n_top, n_sec;

    always_comb begin
        needs = 2'd0;
        room  = 1'b0;
        case (op)
            OP_NOP:     begin needs = 2'd0; room = 1'b0; end
            OP_PUSH:    begin needs = 2'd0; room = 1'b1; end
            OP_POP:     begin needs = 2'd1; room = 1'b0; end
            OP_DUP:     begin needs = 2'd1; room = 1'b1; end
            OP_SWAP:    begin needs = 2'd2; room = 1'b0; end
            OP_OVER:    begin needs = 2'd2; room = 1'b1; end
            OP_REPLACE: begin needs = 2'd1; room = 1'b0; end
            OP_BINOP:   begin needs = 2'd2; room = 1'b0; end
            default:    begin needs = 2'd0; room = 1'b0; end
        endcase
        // Underflow takes priority over overflow when an op lacks both.
        lack_items = OP_VALID && (count_q < IDX_W'(needs));
        lack_room  = OP_VALID && !lack_items && room && (count_q == IDX_W'(DEPTH));
        accept     = OP_VALID && !lack_items && !lack_room;
    end

    always_comb begin
        p_free  = PTR_W'(count_q);
        p_top   = PTR_W'(count_q - IDX_W'(1));
        p_sec   = PTR_W'(count_q - IDX_W'(2));
        mem_d   = mem_q;
        count_d = count_q;
        if (accept) begin
            case (op)
                OP_PUSH: begin
                    mem_d[p_free] = DATA_IN;
                    count_d       = count_q + IDX_W'(1);
                end
                OP_POP: count_d = count_q - IDX_W'(1);
                OP_DUP: begin
                    mem_d[p_free] = mem_q[p_top];
                    count_d       = count_q + IDX_W'(1);
                end
                OP_SWAP: begin
                    mem_d[p_top] = mem_q[p_sec];
                    mem_d[p_sec] = mem_q[p_top];
                end
                OP_OVER: begin
                    mem_d[p_free] = mem_q[p_sec];
                    count_d       = count_q + IDX_W'(1);
                end
                OP_REPLACE: mem_d[p_top] = DATA_IN;
                OP_BINOP: begin
                    mem_d[p_sec] = DATA_IN;
                    count_d      = count_q - IDX_W'(1);
                end
                default: ;
            endcase
        end

        // Top/second are re-registered from the post-op image so outputs stay flop-driven.
        n_top    = PTR_W'(count_d - IDX_W'(1));
        n_sec    = PTR_W'(count_d - IDX_W'(2));
        top_d    = '0;
        second_d = '0;
        if (count_d >= IDX_W'(1)) top_d    = mem_d[n_top];
        if (count_d >= IDX_W'(2)) second_d = mem_d[n_sec];

        ovf_d = (ovf_q & ~CLEAR_ERR) | lack_room;
        udf_d = (udf_q & ~CLEAR_ERR) | lack_items;
        err_d = lack_items | lack_room;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            count_q  <= '0;
            top_q    <= '0;
            second_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            top_q    <= top_d;
            second_q <= second_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign TOP_ITEM    = top_q;
    assign SECOND_ITEM = second_q;
    assign ITEM_COUNT  = COUNT_WIDTH'(count_q);
    assign EMPTY       = (count_q == '0);
    assign FULL        = (count_q == IDX_W'(DEPTH));
    assign OVERFLOW    = ovf_q;
    assign UNDERFLOW   = udf_q;
    assign OP_ERR      = err_q;

endmodule

// File: tb/tb_param_data_stack.sv
// Scoreboard bench: drives a 32x16 and an 8x4 stack with shared stimulus and
// checks every cycle against a queue-fed reference model of the stack rules.
module tb_param_data_stack;

    localparam int W0 = 32;
    localparam int D0 = 16;
    localparam int W1 = 8;
    localparam int D1 = 4;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [2:0]  OP = 3'd0;
    logic        OP_VALID = 1'b0;
    logic [31:0] DATA_IN = '0;
    logic        CLEAR_ERR = 1'b0;

    logic [W0-1:0] top0, sec0;
    logic [31:0]   cnt0;
    logic          empty0, full0, ovf0, udf0, err0;
    logic [W1-1:0] top1, sec1;
    logic [7:0]    cnt1;
    logic          empty1, full1, ovf1, udf1, err1;

    always #5 CLK = ~CLK;

    param_data_stack #(.WIDTH(W0), .DEPTH(D0), .COUNT_WIDTH(32)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .OP(OP), .OP_VALID(OP_VALID),
        .DATA_IN(DATA_IN), .CLEAR_ERR(CLEAR_ERR),
        .TOP_ITEM(top0), .SECOND_ITEM(sec0), .ITEM_COUNT(cnt0),
        .EMPTY(empty0), .FULL(full0), .OVERFLOW(ovf0), .UNDERFLOW(udf0), .OP_ERR(err0)
    );

    param_data_stack #(.WIDTH(W1), .DEPTH(D1), .COUNT_WIDTH(8)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .OP(OP), .OP_VALID(OP_VALID),
        .DATA_IN(DATA_IN[W1-1:0]), .CLEAR_ERR(CLEAR_ERR),
        .TOP_ITEM(top1), .SECOND_ITEM(sec1), .ITEM_COUNT(cnt1),
        .EMPTY(empty1), .FULL(full1), .OVERFLOW(ovf1), .UNDERFLOW(udf1), .OP_ERR(err1)
    );

    typedef struct packed {
        logic [31:0] top;
        logic [31:0] second;
        logic [31:0] count;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        udf;
        logic        err;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: per-op item requirements and a plain array stack.
    int          needs_t [8] = '{0, 0, 1, 1, 2, 2, 1, 2};
    int          room_t  [8] = '{0, 1, 0, 1, 0, 1, 0, 0};
    logic [31:0] mstk [2][16];
    int          mcnt [2];
    logic        movf [2];
    logic        mudf [2];

    task automatic model_step(input int m, input logic rst_n, input logic valid,
                              input logic [2:0] op, input logic [31:0] d,
                              input logic clr, output obs_t o);
        int          dep;
        int          n;
        logic [31:0] dm, x, y;
        logic        err;
        dep = (m == 0) ? D0 : D1;
        dm  = (m == 0) ? d : (d & 32'h0000_00FF);
        err = 1'b0;
        if (!rst_n) begin
            mcnt[m] = 0;
            movf[m] = 1'b0;
            mudf[m] = 1'b0;
        end else begin
            if (clr) begin
                movf[m] = 1'b0;
                mudf[m] = 1'b0;
            end
            if (valid) begin
                n = mcnt[m];
                x = (n >= 1) ? mstk[m][n-1] : '0;
                y = (n >= 2) ? mstk[m][n-2] : '0;
                if (n < needs_t[op]) begin
                    mudf[m] = 1'b1;
                    err     = 1'b1;
                end else if (n + room_t[op] > dep) begin
                    movf[m] = 1'b1;
                    err     = 1'b1;
                end else begin
                    case (op)
                        3'd1: begin mstk[m][n] = dm; mcnt[m] = n + 1; end
                        3'd2: mcnt[m] = n - 1;
                        3'd3: begin mstk[m][n] = x; mcnt[m] = n + 1; end
                        3'd4: begin mstk[m][n-1] = y; mstk[m][n-2] = x; end
                        3'd5: begin mstk[m][n] = y; mcnt[m] = n + 1; end
                        3'd6: mstk[m][n-1] = dm;
                        3'd7: begin mstk[m][n-2] = dm; mcnt[m] = n - 1; end
                        default: ;
                    endcase
                end
            end
        end
        n        = mcnt[m];
        o.top    = (n >= 1) ? mstk[m][n-1] : '0;
        o.second = (n >= 2) ? mstk[m][n-2] : '0;
        o.count  = 32'(n);
        o.empty  = (n == 0);
        o.full   = (n == dep);
        o.ovf    = movf[m];
        o.udf    = mudf[m];
        o.err    = err;
    endtask

    task automatic issue(input logic rst_n, input logic valid, input logic [2:0] op,
                         input logic [31:0] d, input logic clr);
        obs_t e0, e1;
        @(negedge CLK);
        RESET_N   = rst_n;
        OP_VALID  = valid;
        OP        = op;
        DATA_IN   = d;
        CLEAR_ERR = clr;
        model_step(0, rst_n, valid, op, d, clr, e0);
        model_step(1, rst_n, valid, op, d, clr, e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic push(input logic [31:0] d);
        issue(1'b1, 1'b1, 3'd1, d, 1'b0);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] d);
        issue(1'b1, 1'b1, op, d, 1'b0);
    endtask

    // Monitor: the DUT presents a new state after every edge; compare it #1 later.
    always @(posedge CLK) begin
        obs_t e, a;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = '{top0, sec0, cnt0, empty0, full0, ovf0, udf0, err0};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL w32d16 t=%0t got top=%h sec=%h cnt=%0d e/f/o/u/err=%b%b%b%b%b want top=%h sec=%h cnt=%0d e/f/o/u/err=%b%b%b%b%b",
                         $time, a.top, a.second, a.count, a.empty, a.full, a.ovf, a.udf, a.err,
                         e.top, e.second, e.count, e.empty, e.full, e.ovf, e.udf, e.err);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = '{{24'b0, top1}, {24'b0, sec1}, {24'b0, cnt1}, empty1, full1, ovf1, udf1, err1};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL w8d4 t=%0t got top=%h sec=%h cnt=%0d e/f/o/u/err=%b%b%b%b%b want top=%h sec=%h cnt=%0d e/f/o/u/err=%b%b%b%b%b",
                         $time, a.top, a.second, a.count, a.empty, a.full, a.ovf, a.udf, a.err,
                         e.top, e.second, e.count, e.empty, e.full, e.ovf, e.udf, e.err);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rst_n, valid, clr;
        logic [2:0]  op;
        logic [31:0] d;

        // Reset, then PUSH 5, PUSH 7, SWAP.
        issue(1'b0, 1'b0, 3'd0, '0, 1'b0);
        push(32'd5);
        push(32'd7);
        do_op(3'd4, '0);

        // Fill to DEPTH, overflow on PUSH and DUP, then a NOP to see OP_ERR drop.
        issue(1'b0, 1'b0, 3'd0, '0, 1'b0);
        for (int i = 1; i <= D0; i++) push(32'(i));
        push(32'd99);
        do_op(3'd3, '0);
        do_op(3'd0, '0);

        // Underflow from empty, clear, then recover.
        issue(1'b0, 1'b0, 3'd0, '0, 1'b0);
        do_op(3'd2, '0);
        do_op(3'd0, '0);
        issue(1'b1, 1'b0, 3'd0, '0, 1'b1);
        push(32'd3);

        // OVER, BINOP, REPLACE.
        issue(1'b0, 1'b0, 3'd0, '0, 1'b0);
        push(32'd2);
        push(32'd3);
        do_op(3'd5, '0);
        do_op(3'd7, 32'd6);
        do_op(3'd6, 32'd9);

        // SWAP on one item; repeat alongside CLEAR_ERR so the new error wins.
        issue(1'b0, 1'b0, 3'd0, '0, 1'b0);
        push(32'd1);
        do_op(3'd4, '0);
        issue(1'b1, 1'b1, 3'd4, '0, 1'b1);
        issue(1'b1, 1'b0, 3'd0, '0, 1'b1);

        // Full-width data, then reset coinciding with a PUSH.
        push(32'hDEAD_BEEF);
        push(32'hA5C3_0F81);
        push(32'h1234_5678);
        issue(1'b0, 1'b1, 3'd1, 32'd5, 1'b1);
        do_op(3'd0, '0);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            valid = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 9) == 0);
            op    = 3'($urandom_range(0, 7));
            d     = $urandom;
            issue(rst_n, valid, op, d, clr);
        end

        for (int i = 0; i < 5 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge CLK);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
